// File: rtl/pipe_defs.sv
// Shared pipeline definitions for the hazard/stall logic.
// Register-hazard helper and mult/div latency defaults.
package pipe_defs;

  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam int MULT_CYCLES_DEF   = 5;
  localparam int DIV_CYCLES_DEF    = 10;

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_e;

  // One source register against one in-flight producer.
  function automatic logic reg_hit(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] wa,
    input logic [1:0] tnew
  );
    return (src != REG_ZERO) && (tuse != TUSE_NONE) &&
           (src == wa) && (tnew > tuse);
  endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Mult/div occupancy counter: loads the op latency on issue,
// then counts down to idle regardless of stalls or interrupts.
module md_busy_cnt
  import pipe_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  input  logic int_req,
  output logic busy
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  md_state_e        state;

  assign state = (cnt_q == '0) ? MD_IDLE : MD_BUSY;

  // A start seen while busy is ignored: no reload.
  always_comb begin
    cnt_d = cnt_q;
    unique case (state)
      MD_IDLE: begin
        if (start && !int_req)
          cnt_d = is_div ? CNT_W'(DIV_CYCLES)
                         : CNT_W'(MULT_CYCLES);
      end
      MD_BUSY: cnt_d = cnt_q - CNT_W'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign busy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: Tuse/Tnew
// register hazards plus mult/div occupancy.
module hazard_stall_ctrl
  import pipe_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  input  logic [1:0]  D_rs_tuse,
  input  logic [1:0]  D_rt_tuse,
  input  logic        D_is_md,
  input  logic [4:0]  E_wa,
  input  logic [1:0]  E_tnew,
  input  logic [4:0]  M_wa,
  input  logic [1:0]  M_tnew,
  input  logic        E_md_start,
  input  logic        E_md_is_div,
  input  logic        IntReq,
  output logic        pause,
  output logic        E_flush,
  output logic        md_busy,
  output logic [31:0] stall_cycles
);

  logic        stall_rs;
  logic        stall_rt;
  logic        stall_md;
  logic        stall;
  logic [31:0] stall_q;

  md_busy_cnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_cnt (
    .clk     (clk),
    .reset   (reset),
    .start   (E_md_start),
    .is_div  (E_md_is_div),
    .int_req (IntReq),
    .busy    (md_busy)
  );

  assign stall_rs =
    reg_hit(D_rs_addr, D_rs_tuse, E_wa, E_tnew) |
    reg_hit(D_rs_addr, D_rs_tuse, M_wa, M_tnew);
  assign stall_rt =
    reg_hit(D_rt_addr, D_rt_tuse, E_wa, E_tnew) |
    reg_hit(D_rt_addr, D_rt_tuse, M_wa, M_tnew);
  assign stall_md = D_is_md && (E_md_start || md_busy);
  assign stall    = stall_rs | stall_rt | stall_md;

  // Interrupt entry always wins; the pipeline flushes itself.
  assign pause   = stall && !IntReq && !reset;
  assign E_flush = pause;

  always_ff @(posedge clk) begin
    if (reset)
      stall_q <= '0;
    else if (pause && (stall_q != '1))
      stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: vector table,
// directed multi-cycle sequences and a randomized model run.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs_addr, D_rt_addr, E_wa, M_wa;
  logic [1:0]  D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
  logic        D_is_md, E_md_start, E_md_is_div, IntReq;
  logic        pause, E_flush, md_busy;
  logic [31:0] stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .D_rs_addr    (D_rs_addr),
    .D_rt_addr    (D_rt_addr),
    .D_rs_tuse    (D_rs_tuse),
    .D_rt_tuse    (D_rt_tuse),
    .D_is_md      (D_is_md),
    .E_wa         (E_wa),
    .E_tnew       (E_tnew),
    .M_wa         (M_wa),
    .M_tnew       (M_tnew),
    .E_md_start   (E_md_start),
    .E_md_is_div  (E_md_is_div),
    .IntReq       (IntReq),
    .pause        (pause),
    .E_flush      (E_flush),
    .md_busy      (md_busy),
    .stall_cycles (stall_cycles)
  );

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] rs_tuse;
    logic [1:0] rt_tuse;
    logic [4:0] ewa;
    logic [1:0] etnew;
    logic [4:0] mwa;
    logic [1:0] mtnew;
    logic       is_md;
    logic       intreq;
    logic       exp_pause;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    D_rs_addr = 0; D_rt_addr = 0;
    D_rs_tuse = 2'd3; D_rt_tuse = 2'd3;
    D_is_md = 0; E_wa = 0; E_tnew = 0;
    M_wa = 0; M_tnew = 0;
    E_md_start = 0; E_md_is_div = 0; IntReq = 0;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic e_hazard();
    clr();
    E_wa = 5; E_tnew = 2; D_rs_addr = 5; D_rs_tuse = 1;
  endtask

  // Reference: any in-flight producer of a nonzero source that
  // is later than the consumer's need time forces a stall.
  function automatic bit src_hazard(
    input logic [4:0] src, input logic [1:0] tuse,
    input logic [4:0] wa[2], input logic [1:0] tn[2]);
    bit h = 0;
    for (int p = 0; p < 2; p++)
      if (src != 0 && wa[p] == src && int'(tn[p]) > int'(tuse))
        h = 1;
    return h;
  endfunction

  initial begin
    int          cyc;
    int          busy_last;
    longint      cnt_model;
    logic [4:0]  wa[2];
    logic [1:0]  tn[2];
    bit          exp_busy, exp_p;

    tbl[0] = '{0, 0, 0, 3, 0, 2, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 7, 3, 3, 7, 2, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 7, 3, 0, 0, 0, 7, 1, 0, 0, 1};
    tbl[3] = '{0, 7, 3, 1, 0, 0, 7, 1, 0, 0, 0};
    tbl[4] = '{3, 0, 0, 3, 3, 1, 0, 0, 0, 0, 1};
    tbl[5] = '{3, 0, 0, 3, 3, 1, 0, 0, 0, 1, 0};
    tbl[6] = '{3, 0, 2, 3, 3, 2, 0, 0, 0, 0, 0};
    tbl[7] = '{9, 0, 0, 3, 8, 2, 10, 2, 0, 0, 0};
    tbl[8] = '{0, 31, 3, 1, 31, 2, 0, 0, 0, 0, 1};
    tbl[9] = '{0, 0, 3, 3, 0, 0, 0, 0, 1, 0, 0};

    // Reset cycle with a live hazard: outputs gated low.
    reset = 1;
    e_hazard();
    #1;
    settle();
    chk("rst_pause", pause, 0);
    chk("rst_flush", E_flush, 0);
    adv();
    reset = 0;
    settle();
    chk("rst_md_busy", md_busy, 0);
    chk("rst_stall_cycles", stall_cycles, 0);
    chk("e_stall_pause", pause, 1);
    chk("e_stall_flush", E_flush, 1);
    adv();
    E_tnew = 1; M_wa = 5; M_tnew = 1;
    settle();
    chk("e_resolved_pause", pause, 0);
    chk("stall_cnt_one", stall_cycles, 1);
    adv();

    foreach (tbl[i]) begin
      clr();
      D_rs_addr = tbl[i].rs; D_rt_addr = tbl[i].rt;
      D_rs_tuse = tbl[i].rs_tuse; D_rt_tuse = tbl[i].rt_tuse;
      E_wa = tbl[i].ewa; E_tnew = tbl[i].etnew;
      M_wa = tbl[i].mwa; M_tnew = tbl[i].mtnew;
      D_is_md = tbl[i].is_md; IntReq = tbl[i].intreq;
      settle();
      chk($sformatf("tbl%0d_pause", i), pause, tbl[i].exp_pause);
      chk($sformatf("tbl%0d_flush", i), E_flush, tbl[i].exp_pause);
      adv();
    end

    // Mult: busy t+1..t+5, dependent md op stalls t..t+5.
    clr();
    E_md_start = 1; D_is_md = 1;
    settle();
    chk("mult_t_pause", pause, 1);
    chk("mult_t_busy", md_busy, 0);
    adv();
    E_md_start = 0;
    for (int i = 1; i <= 5; i++) begin
      settle();
      chk($sformatf("mult_t%0d_busy", i), md_busy, 1);
      chk($sformatf("mult_t%0d_pause", i), pause, 1);
      adv();
    end
    settle();
    chk("mult_t6_busy", md_busy, 0);
    chk("mult_t6_pause", pause, 0);
    adv();

    // Div with an interrupt mid-flight: counter keeps running.
    clr();
    E_md_start = 1; E_md_is_div = 1; D_is_md = 1;
    settle();
    chk("div_t_pause", pause, 1);
    adv();
    E_md_start = 0;
    for (int i = 1; i <= 10; i++) begin
      IntReq = (i == 3);
      settle();
      chk($sformatf("div_t%0d_busy", i), md_busy, 1);
      chk($sformatf("div_t%0d_pause", i), pause, i != 3);
      adv();
    end
    IntReq = 0;
    settle();
    chk("div_t11_busy", md_busy, 0);
    adv();

    // Victim mult under interrupt never loads.
    clr();
    E_md_start = 1; IntReq = 1;
    settle();
    adv();
    clr();
    settle();
    chk("victim_busy", md_busy, 0);
    adv();

    // Reset at t+4 of a div abandons it.
    clr();
    E_md_start = 1; E_md_is_div = 1;
    settle();
    adv();
    E_md_start = 0; D_is_md = 1;
    for (int i = 1; i <= 3; i++) adv();
    reset = 1;
    settle();
    chk("rst_mid_pause", pause, 0);
    adv();
    reset = 0;
    clr();
    settle();
    chk("rst_mid_busy", md_busy, 0);
    chk("rst_mid_stall_cycles", stall_cycles, 0);
    adv();

    // Seven hazard cycles from reset.
    e_hazard();
    for (int i = 0; i < 7; i++) adv();
    clr();
    settle();
    chk("stall_cnt_seven", stall_cycles, 7);

    // Saturation: preload all-ones, keep stalling.
    force dut.stall_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_q;
    e_hazard();
    adv();
    settle();
    chk("sat_pause", pause, 1);
    chk("sat_hold1", stall_cycles, 32'hFFFF_FFFF);
    adv();
    settle();
    chk("sat_hold2", stall_cycles, 32'hFFFF_FFFF);
    adv();

    // Randomized run against the reference model.
    reset = 1;
    clr();
    adv();
    reset = 0;
    cyc = 0;
    busy_last = -1;
    cnt_model = 0;
    for (int n = 0; n < 400; n++) begin
      D_rs_addr = 5'($urandom_range(0, 3));
      D_rt_addr = 5'($urandom_range(0, 3));
      D_rs_tuse = 2'($urandom_range(0, 3));
      D_rt_tuse = 2'($urandom_range(0, 3));
      E_wa = 5'($urandom_range(0, 3));
      M_wa = 5'($urandom_range(0, 3));
      E_tnew = 2'($urandom_range(0, 2));
      M_tnew = 2'($urandom_range(0, 2));
      D_is_md = 1'($urandom_range(0, 1));
      E_md_start = ($urandom_range(0, 3) == 0);
      E_md_is_div = 1'($urandom_range(0, 1));
      IntReq = ($urandom_range(0, 7) == 0);
      wa[0] = E_wa; wa[1] = M_wa;
      tn[0] = E_tnew; tn[1] = M_tnew;
      exp_busy = (cyc <= busy_last);
      exp_p = (src_hazard(D_rs_addr, D_rs_tuse, wa, tn) ||
               src_hazard(D_rt_addr, D_rt_tuse, wa, tn) ||
               (D_is_md && (E_md_start || exp_busy))) && !IntReq;
      settle();
      chk("rnd_pause", pause, exp_p);
      chk("rnd_flush", E_flush, exp_p);
      chk("rnd_md_busy", md_busy, exp_busy);
      chk("rnd_stall_cycles", stall_cycles, 32'(cnt_model));
      if (E_md_start && !exp_busy && !IntReq)
        busy_last = cyc + (E_md_is_div ? 10 : 5);
      if (exp_p && cnt_model < 64'hFFFF_FFFF)
        cnt_model++;
      cyc++;
      adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Decides each cycle whether the IF/ID register and PC freeze (`pause`) and whether a bubble enters ID/EX (`E_flush`).
- Decision sources: Tuse/Tnew register-hazard checks, plus a multi-cycle mult/div busy counter it owns.
- Defers to interrupt entry: `IntReq` flushes are applied by the pipeline registers themselves; this block never stalls over them.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu issue.
- DIV_CYCLES, 10, busy cycles after a div/divu issue.
- CNT_W, 4, width of busy counter; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- D_rs_addr  in  5  rs index of instruction in D
- D_rt_addr  in  5  rt index of instruction in D
- D_rs_tuse  in  2  cycles until D needs rs (3 = not used)
- D_rt_tuse  in  2  cycles until D needs rt (3 = not used)
- D_is_md  in  1  D instruction reads/writes HI/LO or is mult/div
- E_wa  in  5  destination register of E instruction (0 = none)
- E_tnew  in  2  cycles until E result is forwardable
- M_wa  in  5  destination register of M instruction
- M_tnew  in  2  cycles until M result is forwardable
- E_md_start  in  1  E holds a mult/div this cycle
- E_md_is_div  in  1  qualifies E_md_start: 1 = div, 0 = mult
- IntReq  in  1  interrupt/exception entry this cycle
- pause  out  1  freeze PC and IF/ID register
- E_flush  out  1  insert bubble into ID/EX register
- md_busy  out  1  mult/div unit occupied
- stall_cycles  out  32  saturating count of cycles with pause=1

Behaviour:
- Reset values (reset sampled at posedge): busy counter 0, md_busy 0, stall_cycles 0.
  - pause and E_flush are combinational and must read 0 in the reset cycle.
- Register hazard (combinational): stall_rs = (D_rs_addr!=0) && ((D_rs_addr==E_wa && E_tnew>D_rs_tuse) || (D_rs_addr==M_wa && M_tnew>D_rs_tuse)). stall_rt is identical on rt.
  - Register 0 never stalls.
  - tuse=3 never stalls, because tnew ≤ 2.
- MD hazard: stall_md = D_is_md && (E_md_start || md_busy).
- stall = stall_rs | stall_rt | stall_md.
- pause = stall && !IntReq && !reset.
- E_flush = pause. No other flush source; IntReq flushing is handled by the pipeline registers.
- Busy counter (sequential, one FSM-equivalent: IDLE when cnt==0, BUSY otherwise):
  - IDLE + E_md_start && !IntReq → cnt <= E_md_is_div ? DIV_CYCLES : MULT_CYCLES.
  - BUSY → cnt <= cnt-1 every cycle. It is not paused by `pause` or IntReq; an issued op always completes.
  - E_md_start while BUSY cannot occur legally, because D is stalled. If it is asserted anyway, ignore it (no reload).
  - E_md_start with IntReq=1 is a victim instruction: no load.
- md_busy = (cnt!=0), registered, so it is high exactly N cycles after the issue edge, where N is the loaded value.
- stall_cycles increments by 1 each cycle pause=1 and saturates at 32'hFFFF_FFFF.
- Reset mid-operation: the counter returns to 0 in the same edge; a pending md op is abandoned.

Decomposition:
- Shared package/header `pipe_defs`:
  - TUSE_NONE = 2'd3
  - MULT_CYCLES and DIV_CYCLES defaults
  - REG_ZERO = 5'd0
- One natural sub-module `md_busy_cnt`: the load/decrement counter producing md_busy.
- Hazard compare stays inline.

Test Plan:
- Stall on E: E_wa=5, E_tnew=2, D_rs_addr=5, D_rs_tuse=1 → pause=1, E_flush=1.
  - Next cycle with E_tnew=1, M_wa=5, M_tnew=1 → pause=0.
- Register zero: D_rs_addr=0, E_wa=0, E_tnew=2, D_rs_tuse=0 → pause=0.
  - Also D_rt_tuse=3 with a matching address and E_tnew=2 → pause=0.
- Mult: E_md_start=1, E_md_is_div=0 at cycle t → md_busy high for cycles t+1..t+5.
  - D_is_md=1 → pause=1 at t..t+5, pause=0 at t+6.
- Div plus interrupt: start a div, then IntReq=1 at t+3 → md_busy remains high through t+10.
  - pause=0 during the IntReq cycle.
  - In a separate run, E_md_start=1 with IntReq=1 → md_busy stays 0.
- Reset mid-div: reset at t+4 → md_busy=0 and stall_cycles=0 after the edge; pause=0 in the reset cycle.
- Counter: hold the hazard for 7 cycles from reset → stall_cycles=7.
  - Force the count to 32'hFFFF_FFFF and keep stalling → value holds.
